// File: rtl/mips_pkg.sv
// Shared register-file write types: address/data widths and the write record
// carried by the long-latency result FIFO.
package mips_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic [DATA_W-1:0]     data;
    } rf_wr_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle between the pipeline/LU side (master) and the write arbiter (slave):
// WB result, LU issue/result handshake, decode hazard check and register-file write port.
interface regfile_write_arbiter_if;
    import mips_pkg::*;

    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_dst;
    logic [DATA_W-1:0]     wb_data;
    logic                  lu_issue;
    logic [REG_ADDR_W-1:0] lu_issue_dst;
    logic                  lu_valid;
    logic [REG_ADDR_W-1:0] lu_dst;
    logic [DATA_W-1:0]     lu_data;
    logic                  lu_ready;
    logic [REG_ADDR_W-1:0] chk_ra;
    logic [REG_ADDR_W-1:0] chk_rb;
    logic                  stall;
    logic [NUM_REGS-1:0]   busy_mask;
    logic                  RegWrite;
    logic [REG_ADDR_W-1:0] regWriteDst;
    logic [DATA_W-1:0]     wdata;

    modport master (
        output wb_valid, wb_dst, wb_data, lu_issue, lu_issue_dst,
               lu_valid, lu_dst, lu_data, chk_ra, chk_rb,
        input  lu_ready, stall, busy_mask, RegWrite, regWriteDst, wdata
    );

    modport slave (
        input  wb_valid, wb_dst, wb_data, lu_issue, lu_issue_dst,
               lu_valid, lu_dst, lu_data, chk_ra, chk_rb,
        output lu_ready, stall, busy_mask, RegWrite, regWriteDst, wdata
    );
endinterface

// File: rtl/wb_fifo.sv
// Small FIFO of pending register writes. The head is read combinationally so the
// arbiter can write and pop an entry on the same edge.
module wb_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  rf_wr_t                 push_data_i,
    input  logic                   pop_i,
    output rf_wr_t                 head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rf_wr_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        // A full FIFO still accepts a push when the head leaves on the same edge.
        do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push_i && full_o && !pop_i));
endmodule

// File: rtl/regfile_write_arbiter.sv
// Drives the register file's single write port from the WB stage, buffered LU results
// or a direct LU bypass, and tracks registers still awaiting an LU write.
module regfile_write_arbiter
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    rf_wr_t                head, wr_sel, lu_res;
    logic                  fifo_full, fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  sel_wb, sel_fifo, sel_byp;
    logic                  lu_ready, lu_fire, push, lu_retire, wr_en;
    logic [REG_ADDR_W-1:0] retire_dst;
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    assign lu_res = {bus.lu_dst, bus.lu_data};

    // WB is never held off; buffered LU results go before a fresh LU result.
    always_comb begin
        sel_wb     = !reset && bus.wb_valid;
        sel_fifo   = !reset && !bus.wb_valid && !fifo_empty;
        sel_byp    = !reset && !bus.wb_valid && fifo_empty && bus.lu_valid;
        lu_ready   = !reset && (!fifo_full || sel_fifo);
        lu_fire    = bus.lu_valid && lu_ready;
        push       = lu_fire && !sel_byp;
        lu_retire  = sel_fifo || sel_byp;
        retire_dst = sel_fifo ? head.dst : bus.lu_dst;
        wr_en      = sel_wb || lu_retire;
        if (sel_wb) begin
            wr_sel = {bus.wb_dst, bus.wb_data};
        end else if (sel_fifo) begin
            wr_sel = head;
        end else if (sel_byp) begin
            wr_sel = lu_res;
        end else begin
            wr_sel = '0;
        end
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (lu_res),
        .pop_i       (sel_fifo),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // A write to r0 still consumes its source; only the enable is suppressed.
    assign bus.RegWrite    = wr_en && (wr_sel.dst != '0);
    assign bus.regWriteDst = wr_sel.dst;
    assign bus.wdata       = wr_sel.data;
    assign bus.lu_ready    = lu_ready;
    assign bus.busy_mask   = busy_q;
    assign bus.stall       = !reset &&
                             ((busy_q[bus.chk_ra] && (bus.chk_ra != '0)) ||
                              (busy_q[bus.chk_rb] && (bus.chk_rb != '0)));

    assign busy_d[0] = 1'b0;
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
        logic set_bit, clr_bit;
        assign set_bit    = bus.lu_issue && (bus.lu_issue_dst == REG_ADDR_W'(gi));
        assign clr_bit    = lu_retire && (retire_dst == REG_ADDR_W'(gi));
        // A new reservation outlives the retirement of the previous one.
        assign busy_d[gi] = set_bit || (busy_q[gi] && !clr_bit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    a_issue_free: assert property (@(posedge clk) disable iff (reset)
        (bus.lu_issue && bus.lu_issue_dst != '0) |->
        (!busy_q[bus.lu_issue_dst] || (lu_retire && retire_dst == bus.lu_issue_dst)));
    a_wb_free: assert property (@(posedge clk) disable iff (reset)
        bus.wb_valid |-> !busy_q[bus.wb_dst]);
    a_lu_reserved: assert property (@(posedge clk) disable iff (reset)
        bus.lu_valid |-> busy_q[bus.lu_dst]);
    a_lu_ctrl_known: assert property (@(posedge clk) disable iff (reset)
        !$isunknown({bus.lu_valid, bus.lu_issue}));
    a_lu_res_known: assert property (@(posedge clk) disable iff (reset)
        bus.lu_valid |-> !$isunknown({bus.lu_dst, bus.lu_data}));
    a_issue_known: assert property (@(posedge clk) disable iff (reset)
        bus.lu_issue |-> !$isunknown(bus.lu_issue_dst));
    a_count_range: assert property (@(posedge clk) disable iff (reset)
        fifo_count <= CNT_W'(DEPTH));
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scenarios followed by constrained-random traffic, every cycle compared
// against a queue-based model of the write-port priority and scoreboard rules.
module tb_regfile_write_arbiter;
    import mips_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    rf_wr_t      m_q[$];
    logic [31:0] m_busy;
    bit          last_acc;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wb_valid     = 1'b0;
        bus.wb_dst       = '0;
        bus.wb_data      = '0;
        bus.lu_issue     = 1'b0;
        bus.lu_issue_dst = '0;
        bus.lu_valid     = 1'b0;
        bus.lu_dst       = '0;
        bus.lu_data      = '0;
        bus.chk_ra       = '0;
        bus.chk_rb       = '0;
    endtask

    function automatic int pick(input logic [31:0] avail);
        int s;
        int i;
        s = int'($urandom_range(0, 31));
        for (int k = 0; k < 32; k++) begin
            i = (s + k) % 32;
            if (avail[i]) return i;
        end
        return -1;
    endfunction

    // One clock: compare against the model mid-cycle, then advance the model at the edge.
    task automatic tick();
        bit                    sel, pop, byp, acc, e_ready, e_stall, c_issue;
        rf_wr_t                w, lu_w;
        logic                  c_lu_valid;
        logic [REG_ADDR_W-1:0] c_idst;
        int                    sz;
        @(negedge clk);
        sel = 0; pop = 0; byp = 0; acc = 0; e_ready = 0; e_stall = 0;
        w = '0;
        lu_w = {bus.lu_dst, bus.lu_data};
        c_lu_valid = bus.lu_valid;
        c_issue = bus.lu_issue;
        c_idst = bus.lu_issue_dst;
        sz = m_q.size();
        if (!reset) begin
            if (bus.wb_valid) begin
                sel = 1; w = {bus.wb_dst, bus.wb_data};
            end else if (sz > 0) begin
                sel = 1; pop = 1; w = m_q[0];
            end else if (c_lu_valid) begin
                sel = 1; byp = 1; w = lu_w;
            end
            e_ready = (sz < DEPTH) || pop;
            acc     = c_lu_valid && e_ready;
            e_stall = (bus.chk_ra != 0 && m_busy[bus.chk_ra]) ||
                      (bus.chk_rb != 0 && m_busy[bus.chk_rb]);
        end
        check("RegWrite", 32'(bus.RegWrite), 32'(sel && w.dst != 0));
        check("regWriteDst", 32'(bus.regWriteDst), 32'(w.dst));
        check("wdata", bus.wdata, w.data);
        check("lu_ready", 32'(bus.lu_ready), 32'(e_ready));
        check("stall", 32'(bus.stall), 32'(e_stall));
        check("busy_mask", bus.busy_mask, m_busy);
        if (sel && w.dst != 0)
            $display("%0t write r%0d <= %08h (%s)", $time, w.dst, w.data,
                     pop ? "fifo" : (byp ? "bypass" : "wb"));
        @(posedge clk);
        if (reset) begin
            m_q.delete();
            m_busy = '0;
        end else begin
            if (pop || byp) m_busy[w.dst] = 1'b0;
            if (pop) void'(m_q.pop_front());
            if (acc && !byp) m_q.push_back(lu_w);
            if (c_issue && c_idst != 0) m_busy[c_idst] = 1'b1;
        end
        last_acc = acc;
        #1;
    endtask

    logic [31:0] pend;
    bit          offering;
    bit          quiet;
    rf_wr_t      offer;
    int          d;
    int          idx;

    initial begin
        checks = 0; errors = 0; m_busy = '0; last_acc = 0;
        reset = 1'b1;
        idle_inputs();
        bus.chk_ra = 5'd8;
        tick();
        tick();

        // Reset released, idle
        reset = 1'b0;
        idle_inputs();
        #1;
        check("t1_regwrite", 32'(bus.RegWrite), 0);
        check("t1_ready", 32'(bus.lu_ready), 1);
        check("t1_busy", bus.busy_mask, 0);
        tick();

        // Reserve r8, stall on it, then bypass its result
        bus.lu_issue = 1'b1; bus.lu_issue_dst = 5'd8;
        tick();
        idle_inputs();
        check("t2_busy", bus.busy_mask, 32'h100);
        bus.chk_ra = 5'd8;
        #1;
        check("t2_stall", 32'(bus.stall), 1);
        tick();
        bus.lu_valid = 1'b1; bus.lu_dst = 5'd8; bus.lu_data = 32'hDEADBEEF;
        #1;
        check("t2_byp_we", 32'(bus.RegWrite), 1);
        check("t2_byp_dst", 32'(bus.regWriteDst), 8);
        check("t2_byp_data", bus.wdata, 32'hDEADBEEF);
        tick();
        idle_inputs();
        check("t2_busy_clr", bus.busy_mask, 0);

        // Contention: WB holds the port while LU results pile up
        for (int i = 9; i <= 14; i++) begin
            idle_inputs();
            bus.lu_issue = 1'b1; bus.lu_issue_dst = 5'(i);
            tick();
        end
        idx = 0;
        for (int cyc = 0; cyc < 40 && !(idx == 6 && m_q.size() == 0); cyc++) begin
            idle_inputs();
            bus.wb_valid = (cyc < 6); bus.wb_dst = 5'd3; bus.wb_data = 32'h11;
            bus.lu_valid = (idx < 6); bus.lu_dst = 5'(9 + idx); bus.lu_data = 32'hA000 + 32'(idx);
            if (cyc == 4) begin
                #1;
                check("t3_full_ready", 32'(bus.lu_ready), 0);
            end
            tick();
            if (last_acc) idx++;
        end
        idle_inputs();
        check("t3_all_accepted", 32'(idx), 6);
        check("t3_busy_clr", bus.busy_mask, 0);

        // Full FIFO: pop and push on the same edge across pointer wrap
        for (int i = 16; i <= 23; i++) begin
            idle_inputs();
            bus.lu_issue = 1'b1; bus.lu_issue_dst = 5'(i);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            idle_inputs();
            bus.wb_valid = 1'b1; bus.wb_dst = 5'd3; bus.wb_data = 32'h22;
            bus.lu_valid = 1'b1; bus.lu_dst = 5'(16 + k); bus.lu_data = 32'hB000 + 32'(k);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            idle_inputs();
            bus.lu_valid = 1'b1; bus.lu_dst = 5'(20 + k); bus.lu_data = 32'hB004 + 32'(k);
            #1;
            check("t4_swap_ready", 32'(bus.lu_ready), 1);
            check("t4_swap_dst", 32'(bus.regWriteDst), 32'(16 + k));
            tick();
        end
        idle_inputs();
        for (int k = 0; k < 5; k++) tick();
        check("t4_busy_clr", bus.busy_mask, 0);

        // Retire and re-reserve r5 together; then a WB write to r0
        bus.lu_issue = 1'b1; bus.lu_issue_dst = 5'd5;
        tick();
        idle_inputs();
        bus.lu_valid = 1'b1; bus.lu_dst = 5'd5; bus.lu_data = 32'h55;
        bus.lu_issue = 1'b1; bus.lu_issue_dst = 5'd5;
        tick();
        idle_inputs();
        check("t5_set_wins", 32'(bus.busy_mask[5]), 1);
        bus.lu_valid = 1'b1; bus.lu_dst = 5'd5; bus.lu_data = 32'h66;
        tick();
        idle_inputs();
        check("t5_busy_clr", bus.busy_mask, 0);
        bus.wb_valid = 1'b1; bus.wb_dst = 5'd0; bus.wb_data = 32'h77;
        #1;
        check("t5_r0_we", 32'(bus.RegWrite), 0);
        tick();

        // Reset with three buffered results outstanding
        for (int i = 9; i <= 11; i++) begin
            idle_inputs();
            bus.lu_issue = 1'b1; bus.lu_issue_dst = 5'(i);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            idle_inputs();
            bus.wb_valid = 1'b1; bus.wb_dst = 5'd3; bus.wb_data = 32'h33;
            bus.lu_valid = 1'b1; bus.lu_dst = 5'(9 + k); bus.lu_data = 32'hC000 + 32'(k);
            tick();
        end
        idle_inputs();
        check("t6_busy_pre", bus.busy_mask, 32'h0E00);
        reset = 1'b1;
        #1;
        check("t6_rst_we", 32'(bus.RegWrite), 0);
        check("t6_rst_ready", 32'(bus.lu_ready), 0);
        tick();
        reset = 1'b0;
        #1;
        check("t6_busy_post", bus.busy_mask, 0);
        check("t6_we_post", 32'(bus.RegWrite), 0);
        check("t6_ready_post", 32'(bus.lu_ready), 1);
        tick();

        // Constrained-random traffic, then drain
        pend = '0; offering = 0; offer = '0;
        for (int c = 0; c < 800; c++) begin
            quiet = (c >= 400);
            if (quiet && pend == 0 && !offering && m_q.size() == 0) break;
            idle_inputs();
            if (!offering && pend != 0 && $urandom_range(0, 2) != 0) begin
                d = pick(pend);
                offering = 1; offer.dst = 5'(d); offer.data = $urandom(); pend[d] = 1'b0;
            end
            bus.lu_valid = offering; bus.lu_dst = offer.dst; bus.lu_data = offer.data;
            if (!quiet && $urandom_range(0, 2) == 0) begin
                d = pick(~m_busy);
                if (d >= 0) begin
                    bus.wb_valid = 1'b1; bus.wb_dst = 5'(d); bus.wb_data = $urandom();
                end
            end
            if (!quiet && $urandom_range(0, 3) == 0) begin
                d = pick(~m_busy & ~32'h1);
                if (d > 0) begin
                    bus.lu_issue = 1'b1; bus.lu_issue_dst = 5'(d);
                end
            end
            bus.chk_ra = 5'($urandom_range(0, 31));
            bus.chk_rb = 5'($urandom_range(0, 31));
            tick();
            if (bus.lu_issue) pend[bus.lu_issue_dst] = 1'b1;
            if (offering && last_acc) offering = 0;
        end
        idle_inputs();
        #1;
        check("rand_drained_busy", bus.busy_mask, 0);
        check("rand_drained_ready", 32'(bus.lu_ready), 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
